fifo_wide_to_narrow: RTL and testbench
======================================

Name: fifo_wide_to_narrow

Overview:
- Width-converting FIFO: accepts wide words on the write side and delivers them as narrow lanes on the read side, lowest lane first.
- Counterpart to the narrow-write/wide-read FIFO path in the data-width-conversion design; used where a wide producer feeds a byte-oriented consumer (e.g. UART TX).
- Contains the storage, the write-word and read-lane pointers, and the full/empty/level status.

Parameters:
- NARROW_WIDTH, 8, read-side data width in bits.
- RATIO, 2, narrow lanes per wide word; must be a power of 2 and ≥ 2. WIDE_WIDTH = NARROW_WIDTH*RATIO.
- ADDR_WIDTH, 4, wide-word address bits; DEPTH = 2**ADDR_WIDTH wide entries.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- write_i  input  1  write request; accepted only when full_o=0.
- write_data_i  input  WIDE_WIDTH  wide word to enqueue.
- read_i  input  1  read (pop one lane) request; accepted only when empty_o=0.
- read_data_o  output  NARROW_WIDTH  current head lane, first-word-fall-through.
- empty_o  output  1  no unread lanes remain.
- full_o  output  1  no free wide slot remains.
- level_o  output  ADDR_WIDTH+$clog2(RATIO)+1  unread lanes, in narrow units.

Behaviour:
- Reset (async, on posedge reset_i): wr_ptr=0, rd_ptr=0, empty_o=1, full_o=0, level_o=0. Storage is not reset. read_data_o is don't-care while empty_o=1.
- Pointers:
  - wr_ptr is ADDR_WIDTH+1 bits (wrap bit plus word address).
  - rd_ptr is ADDR_WIDTH+1+LANE_BITS bits, where LANE_BITS=$clog2(RATIO); the low LANE_BITS bits select the lane.
  - Both wrap naturally modulo their width.
- Write accept: write_i && !full_o. On the clock edge, mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data_i and wr_ptr increments by 1.
- Read accept: read_i && !empty_o. On the clock edge, rd_ptr increments by 1 (next lane). It moves to the next word after lane RATIO-1.
- read_data_o:
  - Equals lane rd_ptr[LANE_BITS-1:0] of mem[rd word address]. Lane 0 is bits [NARROW_WIDTH-1:0].
  - Combinational from registered state only; no input-to-output combinational path.
  - Zero read latency: valid in the same cycle empty_o=0.
- empty_o = (rd_ptr == {wr_ptr, LANE_BITS'0}).
- full_o = word address bits equal and wrap bits differ between wr_ptr and rd_ptr[top ADDR_WIDTH+1 bits]. A partially read word still occupies its slot.
- level_o = {wr_ptr, LANE_BITS'0} - rd_ptr, unsigned. Ranges 0..DEPTH*RATIO.
- Flag timing: flags are derived from registered pointers, so they update the cycle after the accepting edge.
- Simultaneous events: write and read are each qualified independently against the current-cycle flags.
  - Full and read of the last lane in the same cycle as write_i: the read is accepted and the write is dropped. full_o deasserts next cycle.
  - Empty with write_i && read_i: the write is accepted and the read is ignored. empty_o deasserts next cycle.
  - Neither full nor empty: both are accepted.
- Requests ignored because of full_o or empty_o have no effect on any state; there is no error flag.
- Reset mid-operation: all contents are discarded immediately. The FIFO is empty from the reset assertion onward; requests during reset are ignored.

Decomposition:
- Package fifo_pkg holds:
  - localparam functions/constants for LANE_BITS, DEPTH and WIDE_WIDTH derivation;
  - the typedef for the lane index.
- Sub-module fifo_regfile: DEPTH x WIDE_WIDTH register file with one synchronous write port and one asynchronous read port.
- Lane selection and the pointer/flag logic stay in the top module.

Test Plan (defaults: NARROW_WIDTH=8, RATIO=2, DEPTH=16):
- Reset, then write 16'hBEEF once. Required:
  - next cycle: empty_o=0, read_data_o=8'hEF, level_o=2;
  - pop: read_data_o=8'hBE, level_o=1;
  - pop: empty_o=1, level_o=0.
- Write 16 words 16'h0100..16'h010F back-to-back. Required: full_o=1 after the 16th and level_o=32. A 17th write of 16'hDEAD is dropped; the final drain yields exactly 32 bytes: 00,01,01,01,...,0F,01.
- While full, pop one lane: full_o stays 1 (partial word). Pop the second lane while write_i=1 with 16'h5555 in the same cycle: the write is dropped and full_o=0 next cycle. A subsequent write of 16'h5555 is accepted and full_o=1 again.
- Empty FIFO with write_i=read_i=1 and 16'h1234: the write is accepted, empty_o=0 next cycle, read_data_o=8'h34, level_o=2.
- Wrap-around: stream 40 random words with random read/write throttling. A scoreboard byte order must match, with no overflow/underflow and level_o always equal to the model.
- With 5 words queued and mid-word (1 lane popped), assert reset_i asynchronously between edges: immediately empty_o=1, full_o=0, level_o=0. After release, a new write of 16'hA5C3 reads out C3 then A5.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the width-converting FIFO slice.
// Contents:
//   lane_bits()  - lane select bits for a given narrow-lanes-per-word ratio
//   wide_width() - wide word width from narrow width and ratio
//   fifo_depth() - wide entries for a given word address width
//   lane_idx_t   - lane index type, wide enough for any supported ratio
package fifo_pkg;

  localparam int MAX_LANE_BITS = 8;

  typedef logic [MAX_LANE_BITS-1:0] lane_idx_t;

  function automatic int lane_bits(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic int wide_width(input int narrow_width, input int ratio);
    return narrow_width * ratio;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile
// DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk_i   - clock, rising edge
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data, combinational from raddr_i
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_wide_to_narrow.sv
// fifo_wide_to_narrow
// Width-converting FIFO: wide words in, narrow lanes out, lowest lane first,
// first-word-fall-through on the read side.
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - asynchronous active-high reset
//   write_i      - enqueue write_data_i (ignored while full_o)
//   write_data_i - wide word, NARROW_WIDTH*RATIO bits
//   read_i       - pop one lane (ignored while empty_o)
//   read_data_o  - current head lane, valid whenever empty_o=0
//   empty_o      - no unread lanes remain
//   full_o       - no free wide slot remains
//   level_o      - unread lanes, in narrow units
module fifo_wide_to_narrow
  import fifo_pkg::*;
#(
  parameter int NARROW_WIDTH = 8,
  parameter int RATIO        = 2,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   write_i,
  input  logic [NARROW_WIDTH*RATIO-1:0]          write_data_i,
  input  logic                                   read_i,
  output logic [NARROW_WIDTH-1:0]                read_data_o,
  output logic                                   empty_o,
  output logic                                   full_o,
  output logic [ADDR_WIDTH+$clog2(RATIO):0]      level_o
);

  localparam int LANE_BITS  = lane_bits(RATIO);
  localparam int WIDE_WIDTH = wide_width(NARROW_WIDTH, RATIO);
  localparam int WPTR_W     = ADDR_WIDTH + 1;
  localparam int RPTR_W     = WPTR_W + LANE_BITS;

  logic [WPTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RPTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic                              wr_en;
  logic                              rd_en;
  logic [WPTR_W-1:0]                 rd_word_ptr;
  logic [RPTR_W-1:0]                 wr_lane_ptr;
  logic [WIDE_WIDTH-1:0]             rd_word;
  logic [RATIO-1:0][NARROW_WIDTH-1:0] rd_lanes;
  lane_idx_t                         rd_lane;

  // Write pointer scaled to lane units so it compares directly with rd_ptr.
  assign wr_lane_ptr = {wr_ptr_q, {LANE_BITS{1'b0}}};
  assign rd_word_ptr = rd_ptr_q[RPTR_W-1:LANE_BITS];

  assign empty_o = (rd_ptr_q == wr_lane_ptr);
  // A partially read word still holds its slot, so full compares word pointers.
  assign full_o  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_word_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_word_ptr[ADDR_WIDTH]);
  assign level_o = wr_lane_ptr - rd_ptr_q;

  assign wr_en = write_i && !full_o;
  assign rd_en = read_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_regfile #(
    .WIDTH      (WIDE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (write_data_i),
    .raddr_i (rd_word_ptr[ADDR_WIDTH-1:0]),
    .rdata_o (rd_word)
  );

  assign rd_lanes = rd_word;
  assign rd_lane  = lane_idx_t'(rd_ptr_q[LANE_BITS-1:0]);

  // Lane mux driven only by registered pointer state, never by read_i.
  always_comb begin
    read_data_o = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_idx_t'(i) == rd_lane) begin
        read_data_o = rd_lanes[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wide_to_narrow.sv
// tb_fifo_wide_to_narrow
// Drives fifo_wide_to_narrow with directed and random traffic and compares
// every cycle against a byte-queue model of the FIFO contents.
module tb_fifo_wide_to_narrow;

  localparam int NW    = 8;
  localparam int RATIO = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        write_i = 1'b0;
  logic [15:0] write_data_i = '0;
  logic        read_i = 1'b0;
  logic [7:0]  read_data_o;
  logic        empty_o;
  logic        full_o;
  logic [5:0]  level_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [$];

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  fifo_wide_to_narrow #(
    .NARROW_WIDTH (NW),
    .RATIO        (RATIO),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .write_i      (write_i),
    .write_data_i (write_data_i),
    .read_i       (read_i),
    .read_data_o  (read_data_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .level_o      (level_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Slots in use = whole words still holding at least one unread lane.
  function automatic bit modelFull();
    return ((mq.size() + RATIO - 1) / RATIO) >= DEPTH;
  endfunction

  task automatic checkModel();
    checkOutput("empty", 32'(empty_o), 32'(mq.size() == 0));
    checkOutput("full", 32'(full_o), 32'(modelFull()));
    checkOutput("level", 32'(level_o), 32'(mq.size()));
    if (mq.size() != 0) begin
      checkOutput("rdata", 32'(read_data_o), 32'(mq[0]));
    end
  endtask

  // One clock cycle of traffic; called and returns at posedge + 1.
  task automatic applyStimulus(input logic wr, input logic [15:0] data, input logic rd);
    bit wacc;
    bit racc;
    write_i      = wr;
    write_data_i = data;
    read_i       = rd;
    @(negedge clk_i);
    checkModel();
    wacc = wr && !modelFull();
    racc = rd && (mq.size() != 0);
    @(posedge clk_i);
    #1;
    if (racc) void'(mq.pop_front());
    if (wacc) begin
      for (int l = 0; l < RATIO; l++) mq.push_back(data[l*NW +: NW]);
    end
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  initial begin
    int sent;
    int cyc;
    logic wr;
    logic rd;
    logic [15:0] d;

    // Reset state
    #2;
    checkOutput("reset_empty", 32'(empty_o), 32'd1);
    checkOutput("reset_full", 32'(full_o), 32'd0);
    checkOutput("reset_level", 32'(level_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Single word, two pops
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    checkOutput("beef_empty", 32'(empty_o), 32'd0);
    checkOutput("beef_lane0", 32'(read_data_o), 32'h EF);
    checkOutput("beef_level2", 32'(level_o), 32'd2);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("beef_lane1", 32'(read_data_o), 32'h BE);
    checkOutput("beef_level1", 32'(level_o), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("beef_drained", 32'(empty_o), 32'd1);
    checkOutput("beef_level0", 32'(level_o), 32'd0);

    // Fill to full, overflow attempt, ordered drain
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
    checkOutput("fill_full", 32'(full_o), 32'd1);
    checkOutput("fill_level", 32'(level_o), 32'd32);
    applyStimulus(1'b1, 16'hDEAD, 1'b0);
    checkOutput("overflow_level", 32'(level_o), 32'd32);
    for (int k = 0; k < 32; k++) begin
      checkOutput("drain_byte", 32'(read_data_o), (k % 2 == 0) ? 32'(k / 2) : 32'h01);
      applyStimulus(1'b0, 16'h0, 1'b1);
    end
    checkOutput("drain_empty", 32'(empty_o), 32'd1);

    // Partial word keeps full; last-lane pop beats a simultaneous write
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("partial_full", 32'(full_o), 32'd1);
    checkOutput("partial_level", 32'(level_o), 32'd31);
    applyStimulus(1'b1, 16'h5555, 1'b1);
    checkOutput("pop_write_full", 32'(full_o), 32'd0);
    checkOutput("pop_write_level", 32'(level_o), 32'd30);
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("refill_full", 32'(full_o), 32'd1);
    checkOutput("refill_level", 32'(level_o), 32'd32);
    while (mq.size() != 0) applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("refill_drained", 32'(empty_o), 32'd1);

    // Empty with simultaneous write and read
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("wr_rd_empty", 32'(empty_o), 32'd0);
    checkOutput("wr_rd_data", 32'(read_data_o), 32'h34);
    checkOutput("wr_rd_level", 32'(level_o), 32'd2);
    applyStimulus(1'b0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b1);

    // Random throttled streaming with wrap-around
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || mq.size() != 0) && cyc < 3000) begin
      wr = (sent < 40) && ($urandom_range(3) != 0);
      rd = (sent >= 40) ? 1'b1 : 1'($urandom_range(1));
      d  = 16'($urandom);
      if (wr && !modelFull()) sent++;
      applyStimulus(wr, d, rd);
      cyc++;
    end
    checkOutput("random_done", 32'(sent == 40 && mq.size() == 0), 32'd1);
    checkOutput("random_empty", 32'(empty_o), 32'd1);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("prereset_level", 32'(level_o), 32'd9);
    #3;
    reset_i = 1'b1;
    #1;
    checkOutput("async_empty", 32'(empty_o), 32'd1);
    checkOutput("async_full", 32'(full_o), 32'd0);
    checkOutput("async_level", 32'(level_o), 32'd0);
    mq.delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    applyStimulus(1'b1, 16'hA5C3, 1'b0);
    checkOutput("post_reset_lane0", 32'(read_data_o), 32'h C3);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("post_reset_lane1", 32'(read_data_o), 32'h A5);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("post_reset_empty", 32'(empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
